// File: rtl/grn_pkg.sv
// Shared definitions for the GRN attractor controller.
//   state_t        : controller FSM states
//   N_DEF / CW_DEF : default node count and counter width
//   MAX_STEPS_DEF  : default step bound for the detect and period phases
package grn_pkg;

  localparam int N_DEF         = 16;
  localparam int CW_DEF        = 16;
  localparam int MAX_STEPS_DEF = 1000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    PER  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/grn_vec_eq.sv
// N-bit vector equality qualified by a minimum step count.
//   a, b  : vectors to compare
//   count : current step count
//   eq    : 1 when a == b and count >= MIN
// Purely combinational; both inputs come straight from registered node outputs.
module grn_vec_eq #(
  parameter int N   = 16,
  parameter int CW  = 16,
  parameter int MIN = 1
) (
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [CW-1:0] count,
  output logic          eq
);

  localparam logic [CW-1:0] MIN_C = CW'(MIN);

  assign eq = (count >= MIN_C) && (a == b);

endmodule

// File: rtl/grn_attractor_ctrl.sv
// Floyd cycle detection controller for a GRN node array.
// Loads an initial state into every node, runs a slow copy (s0, one update
// every second step) against a fast copy (s1, one update per step) until
// they meet, then steps s1 alone until it returns to s0 to measure the
// attractor period. One result per accepted initial state.
//   start/init_valid/init_ready/init_data : initial-state handshake
//   reset_nos/init_state                  : node load pulse and load value
//   start_s0/start_s1                     : node step enables (slow / fast)
//   s0_vec/s1_vec                         : node outputs of the two copies
//   res_*                                 : result handshake and payload
module grn_attractor_ctrl
  import grn_pkg::*;
#(
  parameter int N         = N_DEF,
  parameter int CW        = CW_DEF,
  parameter int MAX_STEPS = MAX_STEPS_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          init_valid,
  output logic          init_ready,
  input  logic [N-1:0]  init_data,
  output logic          reset_nos,
  output logic [N-1:0]  init_state,
  output logic          start_s0,
  output logic          start_s1,
  input  logic [N-1:0]  s0_vec,
  input  logic [N-1:0]  s1_vec,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_state,
  output logic [CW-1:0] res_steps,
  output logic [CW-1:0] res_period,
  output logic          res_timeout
);

  localparam logic [CW-1:0] MAX_C = CW'(MAX_STEPS);

  state_t        state_reg, state_next;
  logic [CW-1:0] steps_reg, per_reg;
  logic [N-1:0]  init_state_reg, res_state_reg;
  logic [CW-1:0] res_steps_reg, res_period_reg;
  logic          res_timeout_reg;

  logic hit, phit, run_to, per_to;

  // After one step s0 and s1 are both f(x), a meaningless match; require
  // at least two steps before the copies are considered to have met.
  grn_vec_eq #(.N(N), .CW(CW), .MIN(2)) u_eq_run (
    .a(s0_vec), .b(s1_vec), .count(steps_reg), .eq(hit)
  );

  // The copies are equal on entry to the period phase; ignore that match.
  grn_vec_eq #(.N(N), .CW(CW), .MIN(1)) u_eq_per (
    .a(s1_vec), .b(s0_vec), .count(per_reg), .eq(phit)
  );

  assign run_to = (steps_reg == MAX_C) && !hit;
  assign per_to = (per_reg == MAX_C) && !phit;

  always_comb begin
    state_next = state_reg;
    init_ready = 1'b0;
    reset_nos  = 1'b0;
    start_s0   = 1'b0;
    start_s1   = 1'b0;
    res_valid  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        init_ready = start;
        if (start && init_valid) state_next = LOAD;
      end
      LOAD: begin
        reset_nos  = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        // No step is issued on the timeout cycle, so the step counter
        // stops exactly at MAX_STEPS.
        if (hit)         state_next = PER;
        else if (run_to) state_next = DONE;
        else begin
          start_s0 = 1'b1;
          start_s1 = 1'b1;
        end
      end
      PER: begin
        if (phit || per_to) state_next = DONE;
        else                start_s1   = 1'b1;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      steps_reg       <= '0;
      per_reg         <= '0;
      init_state_reg  <= '0;
      res_state_reg   <= '0;
      res_steps_reg   <= '0;
      res_period_reg  <= '0;
      res_timeout_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      unique case (state_reg)
        IDLE: begin
          if (start && init_valid) begin
            init_state_reg <= init_data;
            res_state_reg  <= init_data;
          end
        end
        LOAD: begin
          steps_reg       <= '0;
          per_reg         <= '0;
          res_steps_reg   <= '0;
          res_period_reg  <= '0;
          res_timeout_reg <= 1'b0;
        end
        RUN: begin
          if (hit) begin
            res_steps_reg <= steps_reg;
            per_reg       <= '0;
          end else if (run_to) begin
            res_steps_reg   <= steps_reg;
            res_period_reg  <= '0;
            res_timeout_reg <= 1'b1;
          end else begin
            steps_reg <= steps_reg + CW'(1);
          end
        end
        PER: begin
          if (phit) begin
            res_period_reg <= per_reg;
          end else if (per_to) begin
            res_period_reg  <= '0;
            res_timeout_reg <= 1'b1;
          end else begin
            per_reg <= per_reg + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign init_state  = init_state_reg;
  assign res_state   = res_state_reg;
  assign res_steps   = res_steps_reg;
  assign res_period  = res_period_reg;
  assign res_timeout = res_timeout_reg;

endmodule

// File: tb/tb_grn_attractor_ctrl.sv
// Directed bench for grn_attractor_ctrl with a behavioural 4-node array.
module tb_grn_attractor_ctrl;

  localparam int N  = 4;
  localparam int CW = 16;
  localparam int MS = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          init_valid = 1'b0;
  logic          init_ready;
  logic [N-1:0]  init_data = '0;
  logic          reset_nos;
  logic [N-1:0]  init_state;
  logic          start_s0, start_s1;
  logic [N-1:0]  s0_vec, s1_vec;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [N-1:0]  res_state;
  logic [CW-1:0] res_steps, res_period;
  logic          res_timeout;

  int vectors = 0;
  int miscompares = 0;
  int fsel = 0;

  always #5 clk = ~clk;

  grn_attractor_ctrl #(.N(N), .CW(CW), .MAX_STEPS(MS)) dut (
    .clk(clk), .rst(rst), .start(start), .init_valid(init_valid),
    .init_ready(init_ready), .init_data(init_data), .reset_nos(reset_nos),
    .init_state(init_state), .start_s0(start_s0), .start_s1(start_s1),
    .s0_vec(s0_vec), .s1_vec(s1_vec), .res_valid(res_valid),
    .res_ready(res_ready), .res_state(res_state), .res_steps(res_steps),
    .res_period(res_period), .res_timeout(res_timeout)
  );

  // Network update function: 0 = rotate left, 1 = identity, 2 = +1 mod 16.
  function automatic logic [N-1:0] f_apply(input int sel, input logic [N-1:0] v);
    case (sel)
      0:       return {v[N-2:0], v[N-1]};
      1:       return v;
      default: return v + 4'd1;
    endcase
  endfunction

  // Node array: load on reset_nos, s1 steps on every start_s1, s0 steps on
  // every second start_s0 beginning with the first (pass bit set on load).
  logic [N-1:0] n_s0 = '0, n_s1 = '0;
  logic         n_pass = 1'b0;
  always @(posedge clk) begin
    if (reset_nos) begin
      n_s0   <= init_state;
      n_s1   <= init_state;
      n_pass <= 1'b1;
    end else begin
      if (start_s1) n_s1 <= f_apply(fsel, n_s1);
      if (start_s0) begin
        if (n_pass) n_s0 <= f_apply(fsel, n_s0);
        n_pass <= ~n_pass;
      end
    end
  end
  assign s0_vec = n_s0;
  assign s1_vec = n_s1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; init_valid = 1'b0; res_ready = 1'b0;
    tick(); tick();
    vectors++;
    if ({init_ready, reset_nos, start_s0, start_s1, res_valid, res_timeout} !== 6'b0 ||
        init_state !== '0 || res_state !== '0 || res_steps !== '0 || res_period !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ctrl=%b init_state=%h res_state=%h steps=%0d period=%0d required all 0",
               {init_ready, reset_nos, start_s0, start_s1, res_valid, res_timeout},
               init_state, res_state, res_steps, res_period);
    end
    rst = 1'b0;
    tick();
  endtask

  // Offer x with start high; checks acceptance and the LOAD pulse.
  task automatic offer(input int sel, input logic [N-1:0] x);
    fsel = sel; init_data = x; init_valid = 1'b1; start = 1'b1;
    #1;
    vectors++;
    if (init_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL offer_ready: init_ready=%b required 1", init_ready);
    end
    tick();
    init_valid = 1'b0;
    vectors++;
    if (reset_nos !== 1'b1 || init_state !== x || init_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL load_pulse: reset_nos=%b init_state=%h init_ready=%b required 1/%h/0",
               reset_nos, init_state, init_ready, x);
    end
  endtask

  // Runs until res_valid, counting RUN steps (both enables) and PER steps.
  task automatic wait_result(output int run_n, output int per_n);
    bit seen;
    run_n = 0; per_n = 0; seen = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (res_valid) begin seen = 1; break; end
      if (start_s0 && start_s1) run_n++;
      else if (start_s1) per_n++;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL result_timeout: res_valid=%b required 1 within 200 cycles", res_valid);
    end
  endtask

  task automatic check_result(input string name, input logic [N-1:0] st, input int steps,
                              input int period, input logic to, input int run_n, input int per_n,
                              input int exp_run, input int exp_per);
    vectors++;
    if (res_state !== st || res_steps !== CW'(steps) || res_period !== CW'(period) ||
        res_timeout !== to) begin
      miscompares++;
      $display("FAIL %s_result: state=%h steps=%0d period=%0d timeout=%b required %h/%0d/%0d/%b",
               name, res_state, res_steps, res_period, res_timeout, st, steps, period, to);
    end
    vectors++;
    if (run_n != exp_run || per_n != exp_per) begin
      miscompares++;
      $display("FAIL %s_stepcount: run=%0d per=%0d required %0d/%0d",
               name, run_n, per_n, exp_run, exp_per);
    end
    $display("%s: state=%h steps=%0d period=%0d timeout=%b run=%0d per=%0d",
             name, res_state, res_steps, res_period, res_timeout, run_n, per_n);
  endtask

  task automatic consume();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || init_ready !== start) begin
      miscompares++;
      $display("FAIL consume: res_valid=%b init_ready=%b required 0/%b", res_valid, init_ready, start);
    end
  endtask

  task automatic test_rotl();
    int r, p;
    offer(0, 4'b0001);
    wait_result(r, p);
    check_result("rotl", 4'b0001, 8, 4, 1'b0, r, p, 8, 4);
    consume();
  endtask

  task automatic test_identity();
    int r, p;
    offer(1, 4'b1010);
    wait_result(r, p);
    check_result("identity", 4'b1010, 2, 1, 1'b0, r, p, 2, 1);
    consume();
  endtask

  task automatic test_timeout();
    int r, p;
    offer(2, 4'b0000);
    wait_result(r, p);
    vectors++;
    if (res_timeout !== 1'b1 || res_period !== '0 || r != 16 || p != 0) begin
      miscompares++;
      $display("FAIL timeout_result: timeout=%b period=%0d run=%0d per=%0d required 1/0/16/0",
               res_timeout, res_period, r, p);
    end
    $display("timeout: timeout=%b period=%0d run=%0d", res_timeout, res_period, r);
    consume();
  endtask

  // Result held for five cycles with res_ready low; released on the sixth.
  task automatic test_back_to_back();
    int r, p;
    offer(0, 4'b0010);
    wait_result(r, p);
    init_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      vectors++;
      if (res_valid !== 1'b1 || init_ready !== 1'b0 || res_state !== 4'b0010 ||
          res_steps !== CW'(8) || res_period !== CW'(4) || res_timeout !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: valid=%b ready=%b state=%h steps=%0d period=%0d required 1/0/2/8/4",
                 c, res_valid, init_ready, res_state, res_steps, res_period);
      end
    end
    init_valid = 1'b0;
    res_ready  = 1'b1;
    tick();
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || init_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_release: res_valid=%b init_ready=%b required 0/1", res_valid, init_ready);
    end
    $display("backpressure: released after 6 DONE cycles");
  endtask

  task automatic test_rst_mid_run();
    offer(0, 4'b0100);
    start = 1'b0;
    for (int c = 0; c < 4; c++) tick();  // RUN cycles with steps = 0,1,2,3
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({init_ready, reset_nos, start_s0, start_s1, res_valid, res_timeout} !== 6'b0 ||
        init_state !== '0 || res_state !== '0 || res_steps !== '0 || res_period !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_run: ctrl=%b init_state=%h res_state=%h required all 0",
               {init_ready, reset_nos, start_s0, start_s1, res_valid, res_timeout},
               init_state, res_state);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      vectors++;
      if (res_valid !== 1'b0 || start_s1 !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_no_result: res_valid=%b start_s1=%b required 0/0", res_valid, start_s1);
      end
    end
    $display("rst_mid_run: aborted, no result");
  endtask

  task automatic test_start_gate();
    int r, p;
    fsel = 1; init_data = 4'b0110; init_valid = 1'b1; start = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (init_ready !== 1'b0 || reset_nos !== 1'b0) begin
        miscompares++;
        $display("FAIL start_gate: init_ready=%b reset_nos=%b required 0/0", init_ready, reset_nos);
      end
      tick();
    end
    start = 1'b1;
    #1;
    vectors++;
    if (init_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL start_raise: init_ready=%b required 1", init_ready);
    end
    tick();
    init_valid = 1'b0;
    vectors++;
    if (reset_nos !== 1'b1) begin
      miscompares++;
      $display("FAIL start_load: reset_nos=%b required 1", reset_nos);
    end
    wait_result(r, p);
    check_result("start_gate", 4'b0110, 2, 1, 1'b0, r, p, 2, 1);
    consume();
  endtask

  initial begin
    test_reset();
    test_rotl();
    test_identity();
    test_timeout();
    test_back_to_back();
    test_rst_mid_run();
    test_start_gate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
